alu_control_sequencer: RTL and testbench
========================================

Name: alu_control_sequencer

Overview:
- Control end of the ALU interface: fetches 32-bit instructions and decodes them into the ALU select code, operand-routing controls and register-file addresses.
- Consumes the ALU zero flag to resolve branches and owns the program counter.
- Sits between instruction memory, the 8-register file and the 8-bit ALU (forward/add/and/or, 3-bit select, zero output) of the simple CPU.
- Multi-cycle: every instruction takes a FETCH, EXEC and WB state.

Parameters:
PC_WIDTH, 32, program counter width; PC advances in bytes, 4 per instruction
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  input  1  system clock, rising-edge
RESET  input  1  asynchronous, active-high reset
INSTRUCTION  input  32  instruction word from instruction memory
INSTR_VALID  input  1  INSTRUCTION is valid this cycle
ZERO  input  1  ALU zero flag
PC  output  PC_WIDTH  current instruction address
FETCH_REQ  output  1  request for the instruction at PC
ALUOP  output  3  ALU select: 000 forward, 001 add, 010 and, 011 or
NEG_SEL  output  1  op2 path uses the two's complement of register data
IMM_SEL  output  1  op2 path uses IMMEDIATE instead of register data
IMMEDIATE  output  8  immediate field
READREG1  output  3  register address for op1
READREG2  output  3  register address for op2
WRITEREG  output  3  destination register address
WRITEENABLE  output  1  register file writes ALU result on next CLK rising edge
HALTED  output  1  illegal opcode seen; sequencer stopped

Behaviour:
- Reset is asynchronous, active-high, one clock, CLK/RESET as named above.
- Reset forces: PC=RESET_PC, state=FETCH, IR=0, HALTED=0, WRITEENABLE=0.
- All decode outputs read 0 from the reset IR except FETCH_REQ=1.
- Asserting RESET in any state, including WB, drops WRITEENABLE in the same delta, with no wait for a clock edge.
- Instruction format:
  - [31:24] opcode
  - [23:16] dest, or a signed word offset for j/beq
  - [15:8] src1
  - [7:0] src2 or immediate
  - Register addresses use the low 3 bits of each field.
- Opcodes:
  - 00 loadi: ALUOP 000, IMM_SEL 1, writes
  - 01 mov: ALUOP 000, writes
  - 02 add: ALUOP 001, writes
  - 03 sub: ALUOP 001, NEG_SEL 1, writes
  - 04 and: ALUOP 010, writes
  - 05 or: ALUOP 011, writes
  - 06 j: no write, ALU unused
  - 07 beq: ALUOP 001, NEG_SEL 1, no write
  - 08-FF illegal
- FSM states: FETCH, EXEC, WB, HALT.
- FETCH:
  - FETCH_REQ=1, WRITEENABLE=0.
  - On a rising edge with INSTR_VALID=1: IR<=INSTRUCTION, go to EXEC.
  - Otherwise stay in FETCH; the stall is unbounded and PC is held.
- EXEC:
  - Decode outputs are driven combinationally from IR, which gives the ALU a full cycle to settle.
  - Illegal opcode: go to HALT.
  - Otherwise go to WB.
- WB:
  - Decode outputs are held.
  - WRITEENABLE=1 only for opcodes 00-05.
  - At the leaving edge, PC updates:
    - beq with ZERO=1, or j: PC <= PC+4+(sign_extend(offset)<<2).
    - Otherwise: PC <= PC+4.
  - All PC arithmetic is modulo 2^PC_WIDTH (wraps, no error).
  - Then go to FETCH.
- HALT:
  - HALTED=1, FETCH_REQ=0, WRITEENABLE=0, PC frozen.
  - Left only by RESET.
- Throughput: exactly 3 cycles per instruction when INSTR_VALID is already high in FETCH.
- ZERO is sampled only at the WB leaving edge of beq; it is ignored at all other times.
- INSTRUCTION changes outside the FETCH capture edge have no effect.
- Decode outputs in FETCH reflect the previous IR, but with WRITEENABLE=0.

Test Plan:
- Reset, then loadi: RESET pulse; INSTRUCTION=0x00_04_00_2A with INSTR_VALID=1.
  - After reset: PC=0, FETCH_REQ=1.
  - EXEC: IMM_SEL=1, IMMEDIATE=0x2A, WRITEREG=4, ALUOP=000.
  - WB: WRITEENABLE=1.
  - Next FETCH: PC=4.
- sub 0x03_02_01_03:
  - EXEC/WB: ALUOP=001, NEG_SEL=1, READREG1=1, READREG2=3, WRITEREG=2, WRITEENABLE=1 in WB only.
- beq 0x07_FE_01_02 at PC=0x10:
  - ZERO=1 at WB: next PC=0x0C (0x10+4-8).
  - Repeat with ZERO=0: next PC=0x14, and WRITEENABLE stays 0 throughout.
- Stall and wrap:
  - INSTR_VALID=0 for 5 cycles: FSM stays in FETCH with PC unchanged; it advances 3 cycles after INSTR_VALID rises.
  - j 0x06_01_00_00 at PC=0xFFFFFFF8: next PC=0x00000000.
- Illegal opcode 0x09_00_00_00:
  - HALTED=1 and FETCH_REQ=0 from the cycle after EXEC; PC is frozen for 20 cycles.
  - RESET clears HALTED and sets PC=0.
- Reset mid-operation: assert RESET half-way through WB of an add.
  - WRITEENABLE falls immediately, without waiting for a CLK edge.
  - PC=0 and the FSM is in FETCH.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer
// Multi-cycle control unit for the simple 8-bit CPU. Each instruction goes
// through FETCH, EXEC and WB: the instruction is captured in FETCH, decoded
// combinationally from the instruction register in EXEC/WB, and the program
// counter is updated when WB is left. An illegal opcode parks the unit in
// HALT until RESET.
module alu_control_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         INSTRUCTION,
    input  logic                INSTR_VALID,
    input  logic                ZERO,
    output logic [PC_WIDTH-1:0] PC,
    output logic                FETCH_REQ,
    output logic [2:0]          ALUOP,
    output logic                NEG_SEL,
    output logic                IMM_SEL,
    output logic [7:0]          IMMEDIATE,
    output logic [2:0]          READREG1,
    output logic [2:0]          READREG2,
    output logic [2:0]          WRITEREG,
    output logic                WRITEENABLE,
    output logic                HALTED
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_ir;
    // Cleared by reset so the all-zero reset IR (which would otherwise
    // decode as loadi) drives no control flags until a real capture.
    logic                r_ir_loaded;

    state_t              w_state_next;
    logic                w_ir_load;
    logic                w_pc_load;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_offset;
    logic [7:0]          w_opcode;
    logic                w_legal;
    logic                w_writes;
    logic                w_take_branch;
    logic                w_unused;

    assign w_opcode = r_ir[31:24];
    assign w_legal  = (w_opcode <= OP_BEQ);

    // Signed word offset from the dest field, scaled to bytes.
    assign w_offset = {{(PC_WIDTH-10){r_ir[23]}}, r_ir[23:16], 2'b00};

    // ZERO only matters here, and this only takes effect at the WB leaving edge.
    assign w_take_branch = (w_opcode == OP_J) || ((w_opcode == OP_BEQ) && ZERO);
    assign w_pc_next     = w_take_branch ? (r_pc + PC_WIDTH'(4) + w_offset)
                                         : (r_pc + PC_WIDTH'(4));

    // Bits 15:11 of the src1 field carry no meaning (3-bit register addresses).
    assign w_unused = ^r_ir[15:11];

    // State, PC and instruction register; RESET acts immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_ir_loaded <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_ir_load) begin
                r_ir        <= INSTRUCTION;
                r_ir_loaded <= 1'b1;
            end
            if (w_pc_load) begin
                r_pc <= w_pc_next;
            end
        end
    end

    // Next-state logic and the state-dependent handshake/enable outputs.
    always_comb begin
        w_state_next = r_state;
        w_ir_load    = 1'b0;
        w_pc_load    = 1'b0;
        FETCH_REQ    = 1'b0;
        WRITEENABLE  = 1'b0;
        HALTED       = 1'b0;
        case (r_state)
            S_FETCH: begin
                FETCH_REQ = 1'b1;
                if (INSTR_VALID) begin
                    w_ir_load    = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = w_legal ? S_WB : S_HALT;
            end
            S_WB: begin
                WRITEENABLE  = w_writes;
                w_pc_load    = 1'b1;
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                HALTED = 1'b1;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // Instruction decode, purely from the instruction register.
    always_comb begin
        ALUOP    = 3'b000;
        NEG_SEL  = 1'b0;
        IMM_SEL  = 1'b0;
        w_writes = 1'b0;
        if (r_ir_loaded) begin
            case (w_opcode)
                OP_LOADI: begin IMM_SEL = 1'b1; w_writes = 1'b1; end
                OP_MOV:   begin w_writes = 1'b1; end
                OP_ADD:   begin ALUOP = 3'b001; w_writes = 1'b1; end
                OP_SUB:   begin ALUOP = 3'b001; NEG_SEL = 1'b1; w_writes = 1'b1; end
                OP_AND:   begin ALUOP = 3'b010; w_writes = 1'b1; end
                OP_OR:    begin ALUOP = 3'b011; w_writes = 1'b1; end
                OP_BEQ:   begin ALUOP = 3'b001; NEG_SEL = 1'b1; end
                default:  begin end
            endcase
        end
    end

    assign PC        = r_pc;
    assign IMMEDIATE = r_ir[7:0];
    assign READREG1  = r_ir[10:8];
    assign READREG2  = r_ir[2:0];
    assign WRITEREG  = r_ir[18:16];

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed, table-driven bench for alu_control_sequencer.
module tb_alu_control_sequencer;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic        ZERO;
    logic [31:0] PC;
    logic        FETCH_REQ;
    logic [2:0]  ALUOP;
    logic        NEG_SEL;
    logic        IMM_SEL;
    logic [7:0]  IMMEDIATE;
    logic [2:0]  READREG1;
    logic [2:0]  READREG2;
    logic [2:0]  WRITEREG;
    logic        WRITEENABLE;
    logic        HALTED;

    int n_checks = 0;
    int n_fail   = 0;

    alu_control_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTRUCTION (INSTRUCTION),
        .INSTR_VALID (INSTR_VALID),
        .ZERO        (ZERO),
        .PC          (PC),
        .FETCH_REQ   (FETCH_REQ),
        .ALUOP       (ALUOP),
        .NEG_SEL     (NEG_SEL),
        .IMM_SEL     (IMM_SEL),
        .IMMEDIATE   (IMMEDIATE),
        .READREG1    (READREG1),
        .READREG2    (READREG2),
        .WRITEREG    (WRITEREG),
        .WRITEENABLE (WRITEENABLE),
        .HALTED      (HALTED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic [31:0] pc;
        logic [2:0]  aluop;
        logic        neg;
        logic        imm;
        logic [7:0]  immv;
        logic [2:0]  rr1;
        logic [2:0]  rr2;
        logic [2:0]  wr;
        logic        we;
        logic [31:0] next_pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_decode(input string tag, input vec_t v);
        chk({tag, " ALUOP"},     32'(ALUOP),     32'(v.aluop));
        chk({tag, " NEG_SEL"},   32'(NEG_SEL),   32'(v.neg));
        chk({tag, " IMM_SEL"},   32'(IMM_SEL),   32'(v.imm));
        chk({tag, " IMMEDIATE"}, 32'(IMMEDIATE), 32'(v.immv));
        chk({tag, " READREG1"},  32'(READREG1),  32'(v.rr1));
        chk({tag, " READREG2"},  32'(READREG2),  32'(v.rr2));
        chk({tag, " WRITEREG"},  32'(WRITEREG),  32'(v.wr));
    endtask

    // One instruction with INSTR_VALID already high in FETCH: 3 cycles.
    task automatic run_vec(input vec_t v);
        chk("fetch PC",        PC,                  v.pc);
        chk("fetch FETCH_REQ", 32'(FETCH_REQ),      32'd1);
        chk("fetch WE",        32'(WRITEENABLE),    32'd0);
        INSTRUCTION = v.instr;
        INSTR_VALID = 1'b1;
        ZERO        = ~v.zero;
        @(negedge CLK);  // EXEC
        INSTRUCTION = $urandom;   // must be ignored after capture
        INSTR_VALID = 1'b0;
        chk_decode("exec", v);
        chk("exec WE",        32'(WRITEENABLE), 32'd0);
        chk("exec FETCH_REQ", 32'(FETCH_REQ),   32'd0);
        chk("exec PC",        PC,               v.pc);
        ZERO = v.zero;
        @(negedge CLK);  // WB
        chk_decode("wb", v);
        chk("wb WE",     32'(WRITEENABLE), 32'(v.we));
        chk("wb HALTED", 32'(HALTED),      32'd0);
        chk("wb PC",     PC,               v.pc);
        @(negedge CLK);  // FETCH again
        ZERO = ~v.zero;
        chk("next PC", PC, v.next_pc);
        $display("instr 0x%08h zero=%0b pc 0x%08h -> 0x%08h (expected 0x%08h)",
                 v.instr, v.zero, v.pc, PC, v.next_pc);
    endtask

    initial begin
        //             instr         z   pc            alu   n  i  immv   r1    r2    wr   we  next
        vecs[0] = '{32'h0004002A, 1'b0, 32'h00000000, 3'd0, 0, 1, 8'h2A, 3'd0, 3'd2, 3'd4, 1, 32'h00000004};
        vecs[1] = '{32'h03020103, 1'b0, 32'h00000004, 3'd1, 1, 0, 8'h03, 3'd1, 3'd3, 3'd2, 1, 32'h00000008};
        vecs[2] = '{32'h020D0E0F, 1'b1, 32'h00000008, 3'd1, 0, 0, 8'h0F, 3'd6, 3'd7, 3'd5, 1, 32'h0000000C};
        vecs[3] = '{32'h05010203, 1'b1, 32'h0000000C, 3'd3, 0, 0, 8'h03, 3'd2, 3'd3, 3'd1, 1, 32'h00000010};
        vecs[4] = '{32'h07FE0102, 1'b1, 32'h00000010, 3'd1, 1, 0, 8'h02, 3'd1, 3'd2, 3'd6, 0, 32'h0000000C};
        vecs[5] = '{32'h04030405, 1'b0, 32'h0000000C, 3'd2, 0, 0, 8'h05, 3'd4, 3'd5, 3'd3, 1, 32'h00000010};
        vecs[6] = '{32'h07FE0102, 1'b0, 32'h00000010, 3'd1, 1, 0, 8'h02, 3'd1, 3'd2, 3'd6, 0, 32'h00000014};
        vecs[7] = '{32'h0107000F, 1'b0, 32'h00000014, 3'd0, 0, 0, 8'h0F, 3'd0, 3'd7, 3'd7, 1, 32'h00000018};
        vecs[8] = '{32'h06F70000, 1'b0, 32'h00000018, 3'd0, 0, 0, 8'h00, 3'd0, 3'd0, 3'd7, 0, 32'hFFFFFFF8};
        vecs[9] = '{32'h06010000, 1'b0, 32'hFFFFFFF8, 3'd0, 0, 0, 8'h00, 3'd0, 3'd0, 3'd1, 0, 32'h00000000};

        RESET       = 1'b1;
        INSTRUCTION = '0;
        INSTR_VALID = 1'b0;
        ZERO        = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // Reset state
        chk("reset PC",        PC,               32'h0);
        chk("reset FETCH_REQ", 32'(FETCH_REQ),   32'd1);
        chk("reset WE",        32'(WRITEENABLE), 32'd0);
        chk("reset HALTED",    32'(HALTED),      32'd0);
        chk("reset IMM_SEL",   32'(IMM_SEL),     32'd0);
        chk("reset ALUOP",     32'(ALUOP),       32'd0);
        chk("reset WRITEREG",  32'(WRITEREG),    32'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Stall: 5 cycles without INSTR_VALID, PC held in FETCH.
        INSTR_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            INSTRUCTION = $urandom;
            @(negedge CLK);
            chk("stall PC",        PC,             32'h0);
            chk("stall FETCH_REQ", 32'(FETCH_REQ), 32'd1);
        end
        INSTRUCTION = 32'h0004002A;
        INSTR_VALID = 1'b1;
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        chk("post-stall c1 PC", PC, 32'h0);
        @(negedge CLK);
        chk("post-stall c2 PC", PC, 32'h0);
        @(negedge CLK);
        chk("post-stall c3 PC", PC, 32'h4);
        $display("stall: 5 idle cycles then loadi, pc 0x%08h (expected 0x00000004)", PC);

        // Illegal opcode -> HALT
        INSTRUCTION = 32'h09000000;
        INSTR_VALID = 1'b1;
        @(negedge CLK);  // EXEC
        chk("illegal exec HALTED", 32'(HALTED), 32'd0);
        @(negedge CLK);  // HALT
        chk("halt HALTED",    32'(HALTED),      32'd1);
        chk("halt FETCH_REQ", 32'(FETCH_REQ),   32'd0);
        chk("halt WE",        32'(WRITEENABLE), 32'd0);
        for (int i = 0; i < 20; i++) begin
            INSTRUCTION = 32'h0004002A;
            ZERO        = 1'(i);
            @(negedge CLK);
            chk("halt PC frozen", PC,          32'h4);
            chk("halt held",      32'(HALTED), 32'd1);
        end
        $display("illegal 0x09000000: halted=%0b pc 0x%08h (expected 1, 0x00000004)", HALTED, PC);
        INSTR_VALID = 1'b0;
        RESET = 1'b1;
        #1;
        chk("halt reset HALTED", 32'(HALTED),    32'd0);
        chk("halt reset PC",     PC,             32'h0);
        chk("halt reset FREQ",   32'(FETCH_REQ), 32'd1);
        @(negedge CLK);
        RESET = 1'b0;
        $display("reset from HALT: halted=%0b pc 0x%08h", HALTED, PC);

        // Reset half-way through WB of an add.
        INSTRUCTION = 32'h02030102;
        INSTR_VALID = 1'b1;
        @(negedge CLK);  // EXEC
        INSTR_VALID = 1'b0;
        @(negedge CLK);  // WB
        chk("mid-wb WE before reset", 32'(WRITEENABLE), 32'd1);
        RESET = 1'b1;
        #1;
        chk("mid-wb WE after reset", 32'(WRITEENABLE), 32'd0);
        chk("mid-wb PC",             PC,               32'h0);
        chk("mid-wb FETCH_REQ",      32'(FETCH_REQ),   32'd1);
        chk("mid-wb ALUOP",          32'(ALUOP),       32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("post-reset PC", PC, 32'h0);
        chk("post-reset FETCH_REQ", 32'(FETCH_REQ), 32'd1);
        $display("reset in WB of add: we=%0b pc 0x%08h", WRITEENABLE, PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
